// File: rtl/tag_array_nway.sv
// ============================================================================
// Module   : tag_array_nway
// Purpose  : N-way set-associative tag store with per-way valid bits, a
//            registered hit compare, per-set round-robin victim select and a
//            built-in flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_array_nway #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22,
    parameter int WAYS    = 2,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int SETS   = 2 ** INDEX_W
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               lookup_req,
    input  logic [INDEX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               lookup_rdy,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic [WAY_W-1:0]   rsp_victim,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [WAY_W-1:0]   wr_way,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               inv_en,
    input  logic               flush_req,
    output logic               flush_busy
);

    typedef enum logic [0:0] {
        FLUSH = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_fptr;
    logic [WAYS-1:0]    r_valid [SETS];
    logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
    logic [WAY_W-1:0]   r_rr    [SETS];

    logic               w_idle;
    logic               w_accept;
    logic               w_wr;
    logic               w_inv;
    logic               w_same;
    logic [WAYS-1:0]    w_hitv;
    logic               w_hit;
    logic [WAY_W-1:0]   w_way;
    logic [WAY_W-1:0]   w_victim;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = lookup_req && w_idle;
    assign w_wr     = wr_en  && w_idle;
    assign w_inv    = inv_en && w_idle;
    assign w_same   = (wr_idx == lookup_idx);

    always_comb begin
        w_state_nxt = r_state;
        lookup_rdy  = 1'b0;
        flush_busy  = 1'b1;
        case (r_state)
            FLUSH: begin
                if (r_fptr == INDEX_W'(SETS - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                lookup_rdy = 1'b1;
                flush_busy = 1'b0;
                if (flush_req) begin
                    w_state_nxt = FLUSH;
                end
            end
            default: w_state_nxt = FLUSH;
        endcase
    end

    // Same-cycle fill/invalidate to the looked-up set is folded into the
    // compare so the lookup sees the array as it will be after this edge.
    always_comb begin
        w_hitv = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_inv && w_same && (wr_way == WAY_W'(w))) begin
                w_hitv[w] = 1'b0;
            end else if (w_wr && w_same && (wr_way == WAY_W'(w))) begin
                w_hitv[w] = (wr_tag == lookup_tag);
            end else begin
                w_hitv[w] = r_valid[lookup_idx][w] && (r_tag[lookup_idx][w] == lookup_tag);
            end
        end
    end

    always_comb begin
        w_hit = |w_hitv;
        w_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hitv[w]) begin
                w_way = WAY_W'(w);
            end
        end
    end

    assign w_victim = (w_wr && !w_inv && w_same) ? wr_way + 1'b1 : r_rr[lookup_idx];

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state    <= FLUSH;
            r_fptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_way    <= '0;
            rsp_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            rsp_valid <= w_accept;
            if (w_accept) begin
                rsp_hit    <= w_hit;
                rsp_way    <= w_way;
                rsp_victim <= w_victim;
            end
            if (r_state == FLUSH) begin
                r_valid[r_fptr] <= '0;
                r_fptr          <= r_fptr + 1'b1;
            end else begin
                if (flush_req) begin
                    r_fptr <= '0;
                end
                if (w_wr) begin
                    r_valid[wr_idx][wr_way] <= 1'b1;
                end
                // Invalidate wins over a coincident fill and freezes the RR pointer.
                if (w_inv) begin
                    r_valid[wr_idx][wr_way] <= 1'b0;
                end
                if (w_wr && !w_inv) begin
                    r_rr[wr_idx] <= wr_way + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CK) begin
        if (w_wr) begin
            r_tag[wr_idx][wr_way] <= wr_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tag_array_nway.sv
// ============================================================================
// Module   : tb_tag_array_nway
// Purpose  : Bench for tag_array_nway; a 2-way and a 4-way instance share
//            stimulus and are checked against an array-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tag_array_nway;

    localparam int IW   = 6;
    localparam int TW   = 22;
    localparam int SETS = 64;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          lookup_req;
    logic [IW-1:0] lookup_idx;
    logic [TW-1:0] lookup_tag;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [1:0]    wr_way;
    logic [TW-1:0] wr_tag;
    logic          inv_en;
    logic          flush_req;

    logic          rdy2, valid2, hit2, busy2;
    logic [0:0]    way2, vic2;
    logic          rdy4, valid4, hit4, busy4;
    logic [1:0]    way4, vic4;

    tag_array_nway #(.INDEX_W(IW), .TAG_W(TW), .WAYS(2)) u_dut2 (
        .CK(CK), .RST(RST),
        .lookup_req(lookup_req), .lookup_idx(lookup_idx), .lookup_tag(lookup_tag),
        .lookup_rdy(rdy2), .rsp_valid(valid2), .rsp_hit(hit2), .rsp_way(way2),
        .rsp_victim(vic2), .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way[0:0]),
        .wr_tag(wr_tag), .inv_en(inv_en), .flush_req(flush_req), .flush_busy(busy2)
    );

    tag_array_nway #(.INDEX_W(IW), .TAG_W(TW), .WAYS(4)) u_dut4 (
        .CK(CK), .RST(RST),
        .lookup_req(lookup_req), .lookup_idx(lookup_idx), .lookup_tag(lookup_tag),
        .lookup_rdy(rdy4), .rsp_valid(valid4), .rsp_hit(hit4), .rsp_way(way4),
        .rsp_victim(vic4), .wr_en(wr_en), .wr_idx(wr_idx), .wr_way(wr_way),
        .wr_tag(wr_tag), .inv_en(inv_en), .flush_req(flush_req), .flush_busy(busy4)
    );

    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: index 0 is the 2-way array, index 1 the 4-way array.
    bit            m_on = 1'b0;
    bit            m_valid [2][SETS][4];
    logic [TW-1:0] m_tag   [2][SETS][4];
    int            m_rr    [2][SETS];
    int            m_left  [2];
    int            e_valid [2];
    int            e_hit   [2];
    int            e_way   [2];
    int            e_vic   [2];

    task automatic model_step(input int d);
        int  nw;
        int  ww;
        bit  v;
        logic [TW-1:0] t;
        nw = (d == 0) ? 2 : 4;
        ww = int'(wr_way) % nw;
        if (RST) begin
            m_left[d] = SETS;
            for (int s = 0; s < SETS; s++) m_rr[d][s] = 0;
            e_valid[d] = 0; e_hit[d] = 0; e_way[d] = 0; e_vic[d] = 0;
        end else if (m_left[d] > 0) begin
            for (int w = 0; w < 4; w++) m_valid[d][SETS - m_left[d]][w] = 1'b0;
            m_left[d]--;
            e_valid[d] = 0;
        end else begin
            e_valid[d] = lookup_req ? 1 : 0;
            if (lookup_req) begin
                e_hit[d] = 0;
                e_way[d] = 0;
                for (int w = nw - 1; w >= 0; w--) begin
                    v = m_valid[d][lookup_idx][w];
                    t = m_tag[d][lookup_idx][w];
                    if (wr_en && wr_idx == lookup_idx && ww == w) begin
                        v = 1'b1;
                        t = wr_tag;
                    end
                    if (inv_en && wr_idx == lookup_idx && ww == w) v = 1'b0;
                    if (v && t === lookup_tag) begin
                        e_hit[d] = 1;
                        e_way[d] = w;
                    end
                end
                e_vic[d] = m_rr[d][lookup_idx];
                if (wr_en && !inv_en && wr_idx == lookup_idx) e_vic[d] = (ww + 1) % nw;
            end
            if (wr_en) begin
                m_tag[d][wr_idx][ww]   = wr_tag;
                m_valid[d][wr_idx][ww] = 1'b1;
                if (!inv_en) m_rr[d][wr_idx] = (ww + 1) % nw;
            end
            if (inv_en) m_valid[d][wr_idx][ww] = 1'b0;
            if (flush_req) m_left[d] = SETS;
        end
    endtask

    always @(posedge CK) begin
        if (RST) m_on = 1'b1;
        if (m_on) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge CK) begin
        if (m_on) begin
            chk("busy2",  32'(busy2),  32'(m_left[0] > 0));
            chk("rdy2",   32'(rdy2),   32'(m_left[0] == 0));
            chk("valid2", 32'(valid2), 32'(e_valid[0]));
            chk("hit2",   32'(hit2),   32'(e_hit[0]));
            chk("way2",   32'(way2),   32'(e_way[0]));
            chk("vic2",   32'(vic2),   32'(e_vic[0]));
            chk("busy4",  32'(busy4),  32'(m_left[1] > 0));
            chk("rdy4",   32'(rdy4),   32'(m_left[1] == 0));
            chk("valid4", 32'(valid4), 32'(e_valid[1]));
            chk("hit4",   32'(hit4),   32'(e_hit[1]));
            chk("way4",   32'(way4),   32'(e_way[1]));
            chk("vic4",   32'(vic4),   32'(e_vic[1]));
        end
    end

    task automatic tick();
        @(negedge CK);
    endtask

    task automatic clr();
        lookup_req = 1'b0; lookup_idx = '0; lookup_tag = '0;
        wr_en = 1'b0; wr_idx = '0; wr_way = '0; wr_tag = '0;
        inv_en = 1'b0; flush_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy2 === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic fill(input int idx, input int way, input int tag);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_way = 2'(way); wr_tag = TW'(tag);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic lookup(input int idx, input int tag);
        lookup_req = 1'b1; lookup_idx = IW'(idx); lookup_tag = TW'(tag);
        tick();
        lookup_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int vic_exp [4] = '{1, 2, 3, 0};
        clr();
        RST = 1'b1;
        tick();
        RST = 1'b0;

        // T1: reset flush length and first lookup
        count_busy(n);
        chk("t1_busy_cycles", 32'(n), 32'd64);
        chk("t1_rdy", 32'(rdy2), 32'd1);
        lookup(7, 0);
        chk("t1_valid", 32'(valid2), 32'd1);
        chk("t1_hit", 32'(hit2), 32'd0);
        chk("t1_victim", 32'(vic2), 32'd0);

        // T2: fill then lookup next cycle
        fill(5, 1, 32'h2ABCD);
        lookup(5, 32'h2ABCD);
        chk("t2_valid", 32'(valid2), 32'd1);
        chk("t2_hit", 32'(hit2), 32'd1);
        chk("t2_way", 32'(way2), 32'd1);
        chk("t2_victim", 32'(vic2), 32'd0);
        tick();
        chk("t2_valid_drop", 32'(valid2), 32'd0);
        chk("t2_hit_hold", 32'(hit2), 32'd1);

        // T3: same-cycle fill / invalidate bypass
        wr_en = 1'b1; wr_idx = 9; wr_way = 0; wr_tag = 22'h11;
        lookup(9, 32'h11);
        wr_en = 1'b0;
        chk("t3_fill_hit", 32'(hit2), 32'd1);
        chk("t3_fill_way", 32'(way2), 32'd0);
        inv_en = 1'b1; wr_idx = 9; wr_way = 0;
        lookup(9, 32'h11);
        inv_en = 1'b0;
        chk("t3_inv_hit", 32'(hit2), 32'd0);

        // T4: flush, refused lookups, reset mid-flush
        fill(3, 0, 32'h3A);
        fill(3, 1, 32'h3B);
        flush_req = 1'b1;
        lookup_req = 1'b1; lookup_idx = 3; lookup_tag = 22'h3B;
        tick();
        flush_req = 1'b0;
        chk("t4_flushcyc_valid", 32'(valid2), 32'd1);
        chk("t4_flushcyc_hit", 32'(hit2), 32'd1);
        chk("t4_flushcyc_way", 32'(way2), 32'd1);
        count_busy(n);
        chk("t4_busy_cycles", 32'(n), 32'd64);
        tick();
        lookup_req = 1'b0;
        chk("t4_after_valid", 32'(valid2), 32'd1);
        chk("t4_after_hit", 32'(hit2), 32'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (19) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        count_busy(n);
        chk("t4_restart_cycles", 32'(n), 32'd64);

        // T5: 4-way round-robin victim sequence
        for (int w = 0; w < 4; w++) begin
            fill(0, w, 32'h100 + w);
            lookup(0, 32'h100 + w);
            chk("t5_victim4", 32'(vic4), 32'(vic_exp[w]));
            chk("t5_hit4", 32'(hit4), 32'd1);
            chk("t5_way4", 32'(way4), 32'(w));
        end

        // Mixed random traffic on a few sets to force collisions
        for (int i = 0; i < 100; i++) begin
            lookup_req = 1'($urandom_range(0, 1));
            lookup_idx = IW'($urandom_range(0, 3));
            lookup_tag = TW'($urandom_range(0, 3));
            wr_en      = 1'($urandom_range(0, 1));
            wr_idx     = IW'($urandom_range(0, 3));
            wr_way     = 2'($urandom_range(0, 3));
            wr_tag     = TW'($urandom_range(0, 3));
            inv_en     = ($urandom_range(0, 3) == 0);
            flush_req  = ($urandom_range(0, 49) == 0);
            tick();
        end
        clr();
        count_busy(n);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
